// File: rtl/instr_loader.sv
// Byte-serial program loader: receives a framed, checksummed image over a valid/ready
// byte stream, writes big-endian words into instruction memory and holds the CPU in reset.
//
// state  | meaning
// IDLE   | after reset, waiting for start_i
// CNT_HI | expecting high byte of the word count
// CNT_LO | expecting low byte of the word count; count is range-checked here
// DATA   | assembling 4-byte words, one write pulse per completed word
// CSUM   | expecting the XOR checksum byte
// DONE   | image verified; CPU released one cycle after entry
// ERR    | bad count or checksum; CPU stays held
module instr_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int          MAX_WORDS = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_hold_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  xor_q, xor_d;
    logic [23:0] shift_q, shift_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        hold_q, hold_d;
    logic        ready;
    logic        accept;
    logic [15:0] cnt_full;

    assign ready    = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept   = ready && byte_valid_i;
    assign cnt_full = {cnt_q[15:8], byte_i};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        xor_d      = xor_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d    = S_CNT_HI;
                    word_idx_d = 16'd0;
                    byte_cnt_d = 2'd0;
                    xor_d      = 8'd0;
                end
            end
            S_CNT_HI: begin
                if (accept) begin
                    cnt_d   = {byte_i, 8'h00};
                    xor_d   = xor_q ^ byte_i;
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d = cnt_full;
                    xor_d = xor_q ^ byte_i;
                    if (cnt_full == 16'd0 || cnt_full > 16'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    xor_d = xor_q ^ byte_i;
                    if (byte_cnt_q == 2'd3) begin
                        // Write is registered: pulse appears the cycle after the 4th byte.
                        we_d       = 1'b1;
                        addr_d     = ADDR_BASE + {14'd0, word_idx_q, 2'b00};
                        data_d     = {shift_q, byte_i};
                        word_idx_d = word_idx_q + 16'd1;
                        byte_cnt_d = 2'd0;
                        if (word_idx_q == cnt_q - 16'd1) begin
                            state_d = S_CSUM;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], byte_i};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (byte_i == xor_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Release only once DONE has been held for a full cycle; re-assert as soon as DONE is left.
        hold_d = (state_d != S_DONE) || (state_q != S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            word_idx_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            xor_q      <= 8'd0;
            shift_q    <= 24'd0;
            we_q       <= 1'b0;
            addr_q     <= ADDR_BASE;
            data_q     <= 32'd0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            xor_q      <= xor_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            hold_q     <= hold_d;
        end
    end

    assign byte_ready_o = ready;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: two instances (base 0 and base 0x100) share stimulus;
// a frame-level reference model predicts each write and the final done/err outcome.
module tb_instr_loader;

    localparam logic [31:0] BASE0 = 32'h0;
    localparam logic [31:0] BASE1 = 32'h100;
    localparam int          MAXW  = 128;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, byte_valid_i;
    logic [7:0]  byte_i;
    logic        rdy0, we0, hold0, done0, err0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [31:0] addr0, data0, addr1, data1;

    instr_loader #(.ADDR_BASE(BASE0), .MAX_WORDS(MAXW)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .byte_i(byte_i),
        .byte_valid_i(byte_valid_i), .byte_ready_o(rdy0), .mem_we_o(we0),
        .mem_addr_o(addr0), .mem_data_o(data0), .cpu_hold_o(hold0),
        .done_o(done0), .err_o(err0));

    instr_loader #(.ADDR_BASE(BASE1), .MAX_WORDS(MAXW)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .byte_i(byte_i),
        .byte_valid_i(byte_valid_i), .byte_ready_o(rdy1), .mem_we_o(we1),
        .mem_addr_o(addr1), .mem_data_o(data1), .cpu_hold_o(hold1),
        .done_o(done1), .err_o(err1));

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    logic [7:0]  frm[$];
    int          exp_k0[$], exp_k1[$];
    logic [31:0] exp_w0[$], exp_w1[$];
    int          mk;
    logic [31:0] mw;

    // Scoreboard: every write pulse must match the next predicted word
    always @(negedge clk_i) begin
        if (we0) begin
            if (exp_k0.size() == 0) chk("we_extra0", 32'd1, 32'd0);
            else begin
                mk = exp_k0.pop_front(); mw = exp_w0.pop_front();
                chk("waddr0", addr0, BASE0 + 32'(mk) * 32'd4);
                chk("wdata0", data0, mw);
            end
        end
        if (we1) begin
            if (exp_k1.size() == 0) chk("we_extra1", 32'd1, 32'd0);
            else begin
                mk = exp_k1.pop_front(); mw = exp_w1.pop_front();
                chk("waddr1", addr1, BASE1 + 32'(mk) * 32'd4);
                chk("wdata1", data1, mw);
            end
        end
    end

    // Reference model over the first nsent bytes of frm: status 0 = incomplete, 1 = done, 2 = err
    task automatic model(input int nsent, output int status);
        int          n;
        logic [7:0]  x;
        logic [31:0] w;
        status = 0;
        if (nsent < 2) return;
        n = int'({frm[0], frm[1]});
        if (n == 0 || n > MAXW) begin
            status = 2;
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (4 * k + 6 <= nsent) begin
                w = {frm[4*k+2], frm[4*k+3], frm[4*k+4], frm[4*k+5]};
                exp_k0.push_back(k); exp_w0.push_back(w);
                exp_k1.push_back(k); exp_w1.push_back(w);
            end
        end
        if (nsent == 4 * n + 3) begin
            x = 8'h00;
            for (int i = 0; i < 4 * n + 2; i++) x ^= frm[i];
            status = (x == frm[4*n+2]) ? 1 : 2;
        end
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [15:0] n16;
        logic [7:0]  x;
        n16 = 16'(n);
        frm.delete();
        frm.push_back(n16[15:8]);
        frm.push_back(n16[7:0]);
        for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom_range(0, 255)));
        x = 8'h00;
        foreach (frm[i]) x ^= frm[i];
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        frm.push_back(x);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic send(input int nsent, input int gap_pct, input int start_at);
        bit ok;
        for (int i = 0; i < nsent; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                byte_valid_i = 1'b0;
                @(posedge clk_i); #1;
            end
            byte_i       = frm[i];
            byte_valid_i = 1'b1;
            start_i      = (i == start_at);
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                ok = rdy0;
                @(posedge clk_i); #1;
                start_i = 1'b0;
            end
            if (!ok) begin
                chk("ready_timeout", 32'd0, 32'd1);
                byte_valid_i = 1'b0;
                return;
            end
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic finish_check(input int status);
        chk("pending0", 32'(exp_k0.size()), 32'd0);
        chk("pending1", 32'(exp_k1.size()), 32'd0);
        chk("done0", 32'(done0), 32'(status == 1));
        chk("err0",  32'(err0),  32'(status == 2));
        chk("done1", 32'(done1), 32'(status == 1));
        chk("err1",  32'(err1),  32'(status == 2));
        chk("hold_early", 32'(hold0), 32'd1);
        @(posedge clk_i); #1;
        chk("hold_late0", 32'(hold0), 32'(status != 1));
        chk("hold_late1", 32'(hold1), 32'(status != 1));
        chk("ready_after", 32'(rdy0), 32'd0);
    endtask

    task automatic run_frame(input int gap_pct, input int start_at);
        int st;
        model(frm.size(), st);
        send(frm.size(), gap_pct, start_at);
        finish_check(st);
    endtask

    task automatic chk_reset();
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_we0",   32'(we0),  32'd0);
        chk("rst_we1",   32'(we1),  32'd0);
        chk("rst_addr0", addr0, BASE0);
        chk("rst_addr1", addr1, BASE1);
        chk("rst_data0", data0, 32'd0);
        chk("rst_data1", data1, 32'd0);
        chk("rst_hold",  32'(hold0 & hold1), 32'd1);
        chk("rst_done",  32'(done0 | done1), 32'd0);
        chk("rst_err",   32'(err0 | err1),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        rst_i = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk_reset();
        byte_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("idle_ready", 32'(rdy0), 32'd0);
        chk("idle_hold",  32'(hold0), 32'd1);
        byte_valid_i = 1'b0;

        // Basic two-word load; checksum computed as XOR of all preceding bytes
        frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
        do_start();
        run_frame(0, -1);

        frm[10] = 8'h5F;
        do_start();
        run_frame(0, -1);

        frm = '{8'h00, 8'h00};
        do_start();
        run_frame(0, -1);
        frm = '{8'h00, 8'h81};
        do_start();
        run_frame(0, -1);

        // Gapped basic frame with a stray start mid-DATA
        frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h57};
        do_start();
        run_frame(40, 5);

        for (int r = 0; r < 8; r++) begin
            build_frame($urandom_range(1, 6), $urandom_range(0, 2) == 0);
            do_start();
            run_frame(30, $urandom_range(3, frm.size() - 2));
        end

        build_frame(MAXW, 1'b0);
        do_start();
        run_frame(0, -1);

        // Reset after the 2nd data byte of word 1, then a clean one-word frame
        build_frame(2, 1'b0);
        do_start();
        model(8, st);
        send(8, 0, -1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk_reset();
        chk("abort_pending", 32'(exp_k0.size()), 32'd0);
        build_frame(1, 1'b0);
        do_start();
        run_frame(0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
